// File: rtl/mem_pkg.sv
// mem_pkg: widths, opcode constants and FSM state type shared by the RAM access sequencer.
package mem_pkg;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 32;
    localparam logic [3:0] LDR = 4'b1001;
    localparam logic [3:0] STR = 4'b1010;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
endpackage

// File: rtl/ram_timeout_ctr.sv
// ram_timeout_ctr: counts consecutive ACCESS cycles and flags the cycle in which the count reaches TIMEOUT.
module ram_timeout_ctr #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic expire
);
    logic [4:0] cnt;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) cnt <= '0;
        else cnt <= run ? cnt + 5'd1 : 5'd0;
    end

    // cnt holds the number of earlier ACCESS cycles, so this is the TIMEOUT-th one
    assign expire = run & (cnt == 5'(TIMEOUT - 1));
endmodule

// File: rtl/ram_access_seq.sv
// ram_access_seq: sequences one registered RAM read/write per request with pipeline stall.
// Optional ACCESS timeout abort is enabled by defining RAM_ACCESS_TIMEOUT_EN.
module ram_access_seq
    import mem_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              op_valid,
    input  logic              rw,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic              stall,
    output logic [DATA_W-1:0] rdata,
    output logic              rdata_valid,
    output logic              err,
    output logic              ram_en,
    output logic              ram_we,
    output logic [ADDR_W-1:0] ram_addr,
    output logic [DATA_W-1:0] ram_wdata,
    input  logic [DATA_W-1:0] ram_rdata,
    input  logic              ram_ready
);
    state_t state, next;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic rw_q;
    logic in_access;
    logic accept;
    logic abort;

    assign in_access = (state == ACCESS);
    assign accept = ~in_access & op_valid;

`ifdef RAM_ACCESS_TIMEOUT_EN
    ram_timeout_ctr #(.TIMEOUT(TIMEOUT)) u_ctr (
        .clk(clk),
        .rst_n(rst_n),
        .run(in_access),
        .expire(abort)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) err <= 1'b0;
        else err <= in_access & ~ram_ready & abort;
    end
`else
    assign abort = 1'b0;
    assign err = (TIMEOUT < 0);
`endif

    always_comb begin
        next = state;
        case (state)
            IDLE, DONE: next = op_valid ? ACCESS : IDLE;
            ACCESS:     next = ram_ready ? DONE : (abort ? IDLE : ACCESS);
            default:    next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rw_q    <= 1'b0;
            rdata   <= '0;
        end else begin
            state <= next;
            if (accept) begin
                addr_q  <= addr;
                wdata_q <= wdata;
                rw_q    <= rw;
            end
            if (in_access & ram_ready & rw_q) rdata <= ram_rdata;
        end
    end

    assign stall       = in_access | op_valid;
    assign ram_en      = in_access;
    assign ram_we      = in_access & ~rw_q;
    assign ram_addr    = in_access ? addr_q : '0;
    assign ram_wdata   = in_access ? wdata_q : '0;
    assign rdata_valid = (state == DONE) & rw_q;
endmodule

// File: tb/tb_ram_access_seq.sv
// tb_ram_access_seq: directed self-checking bench for ram_access_seq (timeout scenario under RAM_ACCESS_TIMEOUT_EN).
module tb_ram_access_seq;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        op_valid = 1'b0;
    logic        rw = 1'b0;
    logic [15:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        stall;
    logic [31:0] rdata;
    logic        rdata_valid;
    logic        err;
    logic        ram_en;
    logic        ram_we;
    logic [15:0] ram_addr;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata = '0;
    logic        ram_ready = 1'b0;
    int passed = 0;
    int total = 0;

    ram_access_seq #(.TIMEOUT(4)) dut (
        .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .rw(rw), .addr(addr), .wdata(wdata),
        .stall(stall), .rdata(rdata), .rdata_valid(rdata_valid), .err(err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
        .ram_rdata(ram_rdata), .ram_ready(ram_ready)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #12;
        total++; if ({stall, rdata_valid, err, ram_en, ram_we} !== 5'b0) $display("FAIL reset_ctl got %b want 00000", {stall, rdata_valid, err, ram_en, ram_we}); else passed++;
        total++; if ({rdata, ram_addr, ram_wdata} !== 80'h0) $display("FAIL reset_data got %h want 0", {rdata, ram_addr, ram_wdata}); else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_read_first_cycle();
        op_valid = 1; rw = 1; addr = 16'h0010;
        #1;
        total++; if (stall !== 1'b1) $display("FAIL rd_stall0 got %b want 1", stall); else passed++;
        tick();
        op_valid = 0; ram_ready = 1; ram_rdata = 32'hCAFE_0001;
        #1;
        total++; if ({ram_en, ram_we, ram_addr} !== {2'b10, 16'h0010}) $display("FAIL rd_access got %b%b %h want 10 0010", ram_en, ram_we, ram_addr); else passed++;
        total++; if ({stall, rdata_valid} !== 2'b10) $display("FAIL rd_acc_flags got %b want 10", {stall, rdata_valid}); else passed++;
        tick();
        ram_ready = 0;
        #1;
        total++; if ({rdata_valid, stall, ram_en} !== 3'b100) $display("FAIL rd_done got %b want 100", {rdata_valid, stall, ram_en}); else passed++;
        total++; if (rdata !== 32'hCAFE_0001) $display("FAIL rd_data got %h want cafe0001", rdata); else passed++;
        tick();
        total++; if (rdata_valid !== 1'b0) $display("FAIL rd_single_pulse got %b want 0", rdata_valid); else passed++;
    endtask

    task automatic test_write_wait();
        op_valid = 1; rw = 0; addr = 16'h0020; wdata = 32'h1234_5678;
        tick();
        op_valid = 0; addr = 16'h0; wdata = 32'h0;
        for (int i = 0; i < 4; i++) begin
            if (i == 3) ram_ready = 1;
            #1;
            total++; if ({ram_en, ram_we, ram_addr, ram_wdata, rdata_valid} !== {2'b11, 16'h0020, 32'h1234_5678, 1'b0})
                $display("FAIL wr_cycle%0d got %b%b %h %h %b want 11 0020 12345678 0", i, ram_en, ram_we, ram_addr, ram_wdata, rdata_valid); else passed++;
            tick();
        end
        ram_ready = 0;
        #1;
        total++; if ({rdata_valid, stall, ram_en, ram_we} !== 4'b0) $display("FAIL wr_done got %b want 0000", {rdata_valid, stall, ram_en, ram_we}); else passed++;
        total++; if (rdata !== 32'hCAFE_0001) $display("FAIL wr_rdata_hold got %h want cafe0001", rdata); else passed++;
        tick();
    endtask

    task automatic test_hold_in_access();
        int en_cycles = 0;
        op_valid = 1; rw = 1; addr = 16'h0030;
        tick();
        for (int i = 0; i < 3; i++) begin
            addr = 16'h0040 + 16'(i * 16);
            if (i == 2) begin op_valid = 0; ram_ready = 1; ram_rdata = 32'h0000_AAAA; end
            #1;
            if (ram_en) en_cycles++;
            total++; if ({ram_addr, stall} !== {16'h0030, 1'b1}) $display("FAIL hold_addr%0d got %h %b want 0030 1", i, ram_addr, stall); else passed++;
            tick();
        end
        ram_ready = 0;
        for (int i = 0; i < 3; i++) begin
            if (ram_en) en_cycles++;
            tick();
        end
        total++; if (en_cycles !== 3) $display("FAIL hold_one_access got %0d want 3 enable cycles", en_cycles); else passed++;
        total++; if (rdata !== 32'h0000_AAAA) $display("FAIL hold_rdata got %h want 0000aaaa", rdata); else passed++;
    endtask

    task automatic test_back_to_back();
        op_valid = 1; rw = 1; addr = 16'h0100;
        tick();
        op_valid = 0; ram_ready = 1; ram_rdata = 32'h1111_1111;
        tick();
        op_valid = 1; addr = 16'h0104; ram_ready = 0;
        #1;
        total++; if ({rdata_valid, rdata} !== {1'b1, 32'h1111_1111}) $display("FAIL b2b_first got %b %h want 1 11111111", rdata_valid, rdata); else passed++;
        tick();
        op_valid = 0; ram_ready = 1; ram_rdata = 32'h2222_2222;
        #1;
        total++; if ({ram_en, ram_addr, rdata_valid} !== {1'b1, 16'h0104, 1'b0}) $display("FAIL b2b_reenter got %b %h %b want 1 0104 0", ram_en, ram_addr, rdata_valid); else passed++;
        tick();
        ram_ready = 0;
        #1;
        total++; if ({rdata_valid, rdata} !== {1'b1, 32'h2222_2222}) $display("FAIL b2b_second got %b %h want 1 22222222", rdata_valid, rdata); else passed++;
        tick();
    endtask

    task automatic test_reset_mid_access();
        op_valid = 1; rw = 0; addr = 16'h0200; wdata = 32'hFFFF_FFFF;
        tick();
        op_valid = 0;
        #1;
        total++; if (ram_en !== 1'b1) $display("FAIL rst_pre got %b want 1", ram_en); else passed++;
        rst_n = 0;
        #1;
        total++; if ({stall, rdata_valid, err, ram_en, ram_we, ram_addr, ram_wdata, rdata} !== 85'h0)
            $display("FAIL rst_async got %b %h %h %h want all zero", {stall, rdata_valid, err, ram_en, ram_we}, ram_addr, ram_wdata, rdata); else passed++;
        @(negedge clk);
        rst_n = 1;
        tick();
        op_valid = 1; rw = 1; addr = 16'h0300;
        tick();
        op_valid = 0; ram_ready = 1; ram_rdata = 32'hBEEF_0003;
        #1;
        total++; if ({ram_en, ram_addr} !== {1'b1, 16'h0300}) $display("FAIL rst_next_access got %b %h want 1 0300", ram_en, ram_addr); else passed++;
        tick();
        ram_ready = 0;
        #1;
        total++; if ({rdata_valid, rdata} !== {1'b1, 32'hBEEF_0003}) $display("FAIL rst_next_done got %b %h want 1 beef0003", rdata_valid, rdata); else passed++;
        tick();
    endtask

`ifdef RAM_ACCESS_TIMEOUT_EN
    task automatic test_timeout();
        int vld = 0;
        op_valid = 1; rw = 1; addr = 16'h0400;
        tick();
        op_valid = 0;
        for (int i = 0; i < 4; i++) begin
            total++; if ({ram_en, err} !== 2'b10) $display("FAIL to_wait%0d got %b want 10", i, {ram_en, err}); else passed++;
            if (rdata_valid) vld++;
            tick();
        end
        total++; if ({err, ram_en, stall, rdata_valid} !== 4'b1000) $display("FAIL to_abort got %b want 1000", {err, ram_en, stall, rdata_valid}); else passed++;
        tick();
        if (rdata_valid) vld++;
        total++; if ({err, ram_en, vld} !== {2'b00, 32'd0}) $display("FAIL to_after got %b%b vld=%0d want 00 vld=0", err, ram_en, vld); else passed++;
        total++; if (rdata !== 32'hBEEF_0003) $display("FAIL to_rdata_hold got %h want beef0003", rdata); else passed++;
    endtask
`else
    task automatic test_no_timeout();
        int bad = 0;
        op_valid = 1; rw = 1; addr = 16'h0400;
        tick();
        op_valid = 0;
        for (int i = 0; i < 20; i++) begin
            if ({ram_en, err, rdata_valid} !== 3'b100) bad++;
            tick();
        end
        total++; if (bad !== 0) $display("FAIL nto_wait got %0d bad cycles want 0", bad); else passed++;
        ram_ready = 1; ram_rdata = 32'h5555_0004;
        tick();
        ram_ready = 0;
        #1;
        total++; if ({rdata_valid, err, rdata} !== {2'b10, 32'h5555_0004}) $display("FAIL nto_done got %b%b %h want 10 55550004", rdata_valid, err, rdata); else passed++;
        tick();
    endtask
`endif

    initial begin
        test_reset();
        test_read_first_cycle();
        test_write_wait();
        test_hold_in_access();
        test_back_to_back();
        test_reset_mid_access();
`ifdef RAM_ACCESS_TIMEOUT_EN
        test_timeout();
`else
        test_no_timeout();
`endif
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
